pc_converge: RTL and testbench

PC_CONVERGE -- requirements
Module: pc_converge

---
 rtl/pc_converge.sv | 144 ++++++++++++++
 tb/tb_pc_converge.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_converge.sv
// rtl/pc_converge.sv - lowest-PC reconvergence arbiter over per-thread next_pc sources.
// Optional fast path for uniform PCs: define PC_CONVERGE_UNIFORM_SKIP_EN.
module pc_converge #(
    parameter int THREADS_PER_BLOCK     = 4,
    parameter int PROGRAM_MEM_ADDR_BITS = 8
) (
    input  logic                                               clk,
    input  logic                                               reset,
    input  logic                                               start,
    input  logic [THREADS_PER_BLOCK-1:0]                       thread_enable,
    input  logic [THREADS_PER_BLOCK-1:0]                       thread_ret,
    input  logic [THREADS_PER_BLOCK*PROGRAM_MEM_ADDR_BITS-1:0] thread_next_pc,
    output logic                                               busy,
    output logic                                               done,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0]                   selected_pc,
    output logic [THREADS_PER_BLOCK-1:0]                       active_mask,
    output logic                                               all_halted
);

    localparam int T  = THREADS_PER_BLOCK;
    localparam int W  = PROGRAM_MEM_ADDR_BITS;
    localparam int IW = $clog2(T + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic [IW-1:0]  idx;
    logic [W-1:0]   min_pc;
    logic [T-1:0]   mask;
    logic           found;

    logic [T-1:0]   elig;
    logic [W-1:0]   cur_pc;
    logic           cur_elig;
    logic [T-1:0]   cur_onehot;

    assign elig       = thread_enable & ~thread_ret;
    assign cur_onehot = T'(1) << idx;
    assign busy       = (state != IDLE);

    // idx == T is the settle cycle after the last thread; no thread is selected then.
    always_comb begin
        cur_pc   = '0;
        cur_elig = 1'b0;
        for (int i = 0; i < T; i++) begin
            if (idx == IW'(i)) begin
                cur_pc   = thread_next_pc[i*W +: W];
                cur_elig = elig[i];
            end
        end
    end

`ifdef PC_CONVERGE_UNIFORM_SKIP_EN
    logic         uni_any;
    logic         uni_ok;
    logic [W-1:0] uni_pc;

    always_comb begin
        uni_any = 1'b0;
        uni_ok  = 1'b1;
        uni_pc  = '0;
        for (int i = 0; i < T; i++) begin
            if (elig[i]) begin
                if (!uni_any) begin
                    uni_any = 1'b1;
                    uni_pc  = thread_next_pc[i*W +: W];
                end else if (thread_next_pc[i*W +: W] != uni_pc) begin
                    uni_ok = 1'b0;
                end
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            idx         <= '0;
            min_pc      <= '1;
            mask        <= '0;
            found       <= 1'b0;
            done        <= 1'b0;
            selected_pc <= '0;
            active_mask <= '0;
            all_halted  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
`ifdef PC_CONVERGE_UNIFORM_SKIP_EN
                    if (start && uni_any && uni_ok) begin
                        state       <= DONE;
                        done        <= 1'b1;
                        selected_pc <= uni_pc;
                        active_mask <= elig;
                        all_halted  <= 1'b0;
                    end else
`endif
                    if (start) begin
                        state  <= SCAN;
                        idx    <= '0;
                        min_pc <= '1;
                        mask   <= '0;
                        found  <= 1'b0;
                    end
                end
                SCAN: begin
                    if (idx == IW'(T)) begin
                        state       <= DONE;
                        done        <= 1'b1;
                        selected_pc <= found ? min_pc : '0;
                        active_mask <= mask;
                        all_halted  <= ~found;
                        idx         <= '0;
                    end else begin
                        if (cur_elig) begin
                            if (!found || (cur_pc < min_pc)) begin
                                min_pc <= cur_pc;
                                mask   <= cur_onehot;
                                found  <= 1'b1;
                            end else if (cur_pc == min_pc) begin
                                mask <= mask | cur_onehot;
                            end
                        end
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_converge.sv
// tb/tb_pc_converge.sv - self-checking bench for pc_converge (vectors, corner sequences, random vs model).
module tb_pc_converge;

    localparam int T = 4;
    localparam int W = 8;

    logic           clk;
    logic           reset;
    logic           start;
    logic [T-1:0]   thread_enable;
    logic [T-1:0]   thread_ret;
    logic [T*W-1:0] thread_next_pc;
    logic           busy;
    logic           done;
    logic [W-1:0]   selected_pc;
    logic [T-1:0]   active_mask;
    logic           all_halted;

    int total;
    int passed;

    pc_converge #(
        .THREADS_PER_BLOCK    (T),
        .PROGRAM_MEM_ADDR_BITS(W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .thread_enable (thread_enable),
        .thread_ret    (thread_ret),
        .thread_next_pc(thread_next_pc),
        .busy          (busy),
        .done          (done),
        .selected_pc   (selected_pc),
        .active_mask   (active_mask),
        .all_halted    (all_halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [T-1:0]   en;
        logic [T-1:0]   ret;
        logic [T*W-1:0] pcs;
        logic [W-1:0]   pc;
        logic [T-1:0]   mask;
        logic           halted;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    endtask

    // Reference: lowest eligible PC over the whole block, then everyone sitting at it.
    function automatic void model(input logic [T-1:0] en, input logic [T-1:0] ret,
                                  input logic [T*W-1:0] pcs, output logic [W-1:0] pc,
                                  output logic [T-1:0] mask, output logic halted,
                                  output logic uniform);
        int best;
        logic [T-1:0] el;
        best = 1 << W;
        el   = en & ~ret;
        for (int i = 0; i < T; i++)
            if (el[i] && int'(pcs[i*W +: W]) < best) best = int'(pcs[i*W +: W]);
        halted = (best == (1 << W));
        pc     = halted ? '0 : W'(best);
        mask   = '0;
        for (int i = 0; i < T; i++)
            if (el[i] && int'(pcs[i*W +: W]) == best) mask[i] = 1'b1;
        uniform = !halted && (mask == el);
    endfunction

    function automatic int expected_latency(input logic uniform);
`ifdef PC_CONVERGE_UNIFORM_SKIP_EN
        if (uniform) return 0;
`endif
        return uniform ? T + 1 : T + 1;
    endfunction

    // Latency = posedges after the start-sampling edge before done is seen high.
    task automatic run(input logic [T-1:0] en, input logic [T-1:0] ret, input logic [T*W-1:0] pcs,
                       output logic [W-1:0] gpc, output logic [T-1:0] gmask, output logic ghalt,
                       output int lat, output logic gbusy, output logic gdone_after);
        @(negedge clk);
        thread_enable  = en;
        thread_ret     = ret;
        thread_next_pc = pcs;
        start          = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat   = -1;
        gbusy = 1'b0;
        gpc   = '0;
        gmask = '0;
        ghalt = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) @(posedge clk);
            @(negedge clk);
            if (c == 0) gbusy = busy;
            if (done) begin
                lat   = c;
                gpc   = selected_pc;
                gmask = active_mask;
                ghalt = all_halted;
                break;
            end
        end
        @(negedge clk);
        gdone_after = done | busy;
    endtask

    task automatic run_and_check(input string tag, input logic [T-1:0] en, input logic [T-1:0] ret,
                                 input logic [T*W-1:0] pcs, input logic [W-1:0] epc,
                                 input logic [T-1:0] emask, input logic ehalt, input int elat);
        logic [W-1:0] gpc;
        logic [T-1:0] gmask;
        logic ghalt, gbusy, gafter;
        int lat;
        run(en, ret, pcs, gpc, gmask, ghalt, lat, gbusy, gafter);
        check({tag, ".latency"}, 32'(lat), 32'(elat));
        if (lat >= 0) begin
            check({tag, ".selected_pc"}, 32'(gpc), 32'(epc));
            check({tag, ".active_mask"}, 32'(gmask), 32'(emask));
            check({tag, ".all_halted"}, 32'(ghalt), 32'(ehalt));
            check({tag, ".busy_after_start"}, 32'(gbusy), 32'd1);
            check({tag, ".done_one_cycle"}, 32'(gafter), 32'd0);
        end
    endtask

    vec_t vecs[9];

    initial begin
        logic [W-1:0] mpc, gpc, held_pc;
        logic [T-1:0] mmask, gmask;
        logic mhalt, muni, ghalt, gbusy, gafter;
        logic [T-1:0] en, ret;
        logic [T*W-1:0] pcs;
        int lat, ndone;

        total = 0;
        passed = 0;
        vecs[0] = '{4'hF, 4'h0, 32'h10101010, 8'h10, 4'b1111, 1'b0};
        vecs[1] = '{4'hF, 4'h0, 32'h08300822, 8'h08, 4'b1010, 1'b0};
        vecs[2] = '{4'h7, 4'h2, 32'h00090105, 8'h05, 4'b0001, 1'b0};
        vecs[3] = '{4'hF, 4'hF, 32'h44332211, 8'h00, 4'b0000, 1'b1};
        vecs[4] = '{4'h0, 4'h0, 32'h01020304, 8'h00, 4'b0000, 1'b1};
        vecs[5] = '{4'hF, 4'h0, 32'hFFFEFFFF, 8'hFE, 4'b0100, 1'b0};
        vecs[6] = '{4'hF, 4'h0, 32'hFFFFFFFF, 8'hFF, 4'b1111, 1'b0};
        vecs[7] = '{4'h8, 4'h0, 32'h00000000, 8'h00, 4'b1000, 1'b0};
        vecs[8] = '{4'hF, 4'h0, 32'h7F807F80, 8'h7F, 4'b1010, 1'b0};

        reset = 1'b0;
        start = 1'b0;
        thread_enable = '0;
        thread_ret = '0;
        thread_next_pc = '0;
        repeat (3) @(negedge clk);
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.done", 32'(done), 32'd0);
        check("reset.outputs", {23'd0, all_halted, active_mask, selected_pc}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 9; v++) begin
            model(vecs[v].en, vecs[v].ret, vecs[v].pcs, mpc, mmask, mhalt, muni);
            run_and_check($sformatf("vec%0d", v), vecs[v].en, vecs[v].ret, vecs[v].pcs,
                          vecs[v].pc, vecs[v].mask, vecs[v].halted, expected_latency(muni));
        end

        // Results hold after done even when the thread inputs move.
        held_pc = selected_pc;
        thread_next_pc = 32'h01010101;
        repeat (3) @(negedge clk);
        check("hold.selected_pc", 32'(selected_pc), 32'(held_pc));

        // Reset during the second SCAN cycle clears everything at once.
        run(4'hF, 4'h0, 32'h08300822, gpc, gmask, ghalt, lat, gbusy, gafter);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("midreset.busy", 32'(busy), 32'd0);
        check("midreset.done", 32'(done), 32'd0);
        check("midreset.outputs", {23'd0, all_halted, active_mask, selected_pc}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        run_and_check("after_reset", 4'hF, 4'h0, 32'h08300822, 8'h08, 4'b1010, 1'b0, T + 1);

        // A second start while busy must not produce a second done.
        @(negedge clk);
        thread_enable = 4'hF;
        thread_ret = 4'h0;
        thread_next_pc = 32'h08300822;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        ndone = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b1;
            if (c == 2) start = 1'b0;
            if (done) ndone++;
        end
        check("busy_start.done_count", 32'(ndone), 32'd1);
        check("busy_start.idle", 32'(busy), 32'd0);

        for (int r = 0; r < 30; r++) begin
            en  = T'($urandom);
            ret = T'($urandom) & T'($urandom);
            pcs = '0;
            for (int i = 0; i < T; i++)
                pcs[i*W +: W] = (r % 3 == 0) ? W'($urandom) : W'($urandom_range(0, 3));
            if (r % 7 == 0) pcs = {T{pcs[W-1:0]}};
            model(en, ret, pcs, mpc, mmask, mhalt, muni);
            run_and_check($sformatf("rand%0d", r), en, ret, pcs, mpc, mmask, mhalt,
                          expected_latency(muni));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
